// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image geometry, pixel/sum typedefs and helpers
package img_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_PIX_W    = 8;

    // Block grid of the default frame (2x2 pixel blocks).
    localparam int BLK_W = DEF_H_ACTIVE / 2;
    localparam int BLK_H = DEF_V_ACTIVE / 2;

    typedef logic [DEF_PIX_W-1:0] pix_t;
    typedef logic [DEF_PIX_W:0]   pair_t;
    typedef logic [DEF_PIX_W+1:0] bsum_t;

    // Address width for a memory of n entries, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_pair_ram.sv
// rtl/line_pair_ram.sv - single-port synchronous RAM holding one line of horizontal pixel pairs
module line_pair_ram
    import img_pkg::*;
#(
    parameter int DEPTH = BLK_W,
    parameter int WIDTH = $bits(pair_t),
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write on we; q always reflects the last addressed word, so it holds while addr holds.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        q <= r_mem[addr];
    end

endmodule

// File: rtl/block_sum_encoder.sv
// rtl/block_sum_encoder.sv - 2x2 block-sum encoder for a raster gray pixel stream (optional FRAME_SYNC_EN)
module block_sum_encoder
    import img_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int PIX_W    = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [PIX_W-1:0] gray_int,
`ifdef FRAME_SYNC_EN
    input  logic             sof,
`endif
    output logic [PIX_W+1:0] block_sum,
    output logic             block_valid,
    output logic [8:0]       block_x,
    output logic [7:0]       block_y,
    output logic             frame_done
);

    localparam int         RAM_DEPTH = H_ACTIVE / 2;
    localparam int         RAM_AW    = clog2_min1(RAM_DEPTH);
    localparam logic [9:0] COL_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0] ROW_LAST  = 9'(V_ACTIVE - 1);

    logic [9:0]        r_col;
    logic [8:0]        r_row;
    logic [PIX_W-1:0]  r_p_even;

    logic [PIX_W:0]    w_pair;
    logic [PIX_W:0]    w_ram_q;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_ram_we;
    logic              w_sof;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_blk_done;

`ifdef FRAME_SYNC_EN
    assign w_sof = ce && sof;
`else
    assign w_sof = 1'b0;
`endif

    assign w_pair     = {1'b0, r_p_even} + {1'b0, gray_int};
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // Column pair index is the same for the even and odd pixel, so the read issued on the
    // even column stays on the RAM output through the odd column regardless of ce gaps.
    assign w_ram_addr = RAM_AW'(r_col[9:1]);
    assign w_ram_we   = ce && !w_sof && !r_row[0] && r_col[0];
    assign w_blk_done = ce && !w_sof && r_row[0] && r_col[0];

    line_pair_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (PIX_W + 1),
        .AW    (RAM_AW)
    ) u_line_pair_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (w_pair),
        .q    (w_ram_q)
    );

    // Raster position counters and the even-column pixel latch; sof restarts at (0,0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_p_even <= '0;
        end else if (w_sof) begin
            r_col    <= 10'd1;
            r_row    <= '0;
            r_p_even <= gray_int;
        end else if (ce) begin
            if (!r_col[0]) begin
                r_p_even <= gray_int;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? 9'd0 : r_row + 9'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Registered block output: sum of upper pair from the line RAM and the current lower pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            block_sum   <= '0;
            block_valid <= 1'b0;
            block_x     <= '0;
            block_y     <= '0;
            frame_done  <= 1'b0;
        end else begin
            block_valid <= w_blk_done;
            frame_done  <= w_blk_done && w_col_last && w_row_last;
            if (w_blk_done) begin
                block_sum <= {1'b0, w_ram_q} + {1'b0, w_pair};
                block_x   <= r_col[9:1];
                block_y   <= r_row[8:1];
            end
        end
    end

endmodule

// File: tb/tb_block_sum_encoder.sv
// tb/tb_block_sum_encoder.sv - directed self-checking bench for block_sum_encoder on a reduced frame
module tb_block_sum_encoder;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int BW = H / 2;
    localparam int BH = V / 2;
    localparam int NB = BW * BH;

    typedef struct {
        logic [9:0] s;
        logic [8:0] x;
        logic [7:0] y;
        logic       fd;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] gray_int = '0;
`ifdef FRAME_SYNC_EN
    logic       sof = 1'b0;
`endif
    logic [9:0] block_sum;
    logic       block_valid;
    logic [8:0] block_x;
    logic [7:0] block_y;
    logic       frame_done;

    int   n_checks = 0;
    int   n_fail = 0;
    rec_t q[$];

    block_sum_encoder #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .PIX_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .gray_int    (gray_int),
`ifdef FRAME_SYNC_EN
        .sof         (sof),
`endif
        .block_sum   (block_sum),
        .block_valid (block_valid),
        .block_x     (block_x),
        .block_y     (block_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (block_valid === 1'b1) begin
            q.push_back('{s: block_sum, x: block_x, y: block_y, fd: frame_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int kind, input logic [7:0] c);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                ce       = 1'b1;
                gray_int = (kind == 0) ? c : 8'((x + y) & 255);
                tick();
                ce = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ce  = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (block_valid !== 1'b0 || frame_done !== 1'b0 || block_sum !== 10'd0 ||
            block_x !== 9'd0 || block_y !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b done=%b sum=%0d x=%0d y=%0d, want all 0",
                     block_valid, frame_done, block_sum, block_x, block_y);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_constant(input logic [7:0] c, input logic [9:0] exp_sum, input string name);
        int nfd;
        q.delete();
        drive_frame(0, c);
        n_checks++;
        if (q.size() != NB) begin
            n_fail++;
            $display("FAIL %s_count: got %0d valids, want %0d", name, q.size(), NB);
        end
        nfd = 0;
        foreach (q[i]) begin
            n_checks++;
            if (q[i].s !== exp_sum || q[i].x !== 9'(i % BW) || q[i].y !== 8'(i / BW)) begin
                n_fail++;
                $display("FAIL %s_block%0d: got sum=%0d (%0d,%0d), want sum=%0d (%0d,%0d)",
                         name, i, q[i].s, q[i].x, q[i].y, exp_sum, i % BW, i / BW);
            end
            if (q[i].fd === 1'b1) nfd++;
        end
        n_checks++;
        if (nfd != 1 || q.size() != NB || q[NB-1].fd !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %0d pulses, want exactly 1 on block (%0d,%0d)",
                     name, nfd, BW - 1, BH - 1);
        end
    endtask

    // Ramp pixel (x+y): the 2x2 block at (bx,by) sums to 8*(bx+by)+4.
    task automatic test_ramp(input bit gaps, input string name);
        logic exp_v;
        q.delete();
        if (!gaps) begin
            drive_frame(1, 8'd0);
        end else begin
            for (int y = 0; y < V; y++) begin
                for (int x = 0; x < H; x++) begin
                    ce       = 1'b1;
                    gray_int = 8'((x + y) & 255);
                    tick();
                    ce    = 1'b0;
                    exp_v = (x % 2 == 1) && (y % 2 == 1);
                    n_checks++;
                    if (block_valid !== exp_v) begin
                        n_fail++;
                        $display("FAIL %s_valid_at(%0d,%0d): got %b, want %b", name, x, y, block_valid, exp_v);
                    end
                    repeat ($urandom_range(0, 2)) begin
                        tick();
                        n_checks++;
                        if (block_valid !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s_gap_valid(%0d,%0d): got %b, want 0", name, x, y, block_valid);
                        end
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (q.size() != NB) begin
            n_fail++;
            $display("FAIL %s_count: got %0d valids, want %0d", name, q.size(), NB);
        end
        n_checks++;
        if (q.size() == 0 || q[0].s !== 10'd4) begin
            n_fail++;
            $display("FAIL %s_block00: got %0d, want 4", name, (q.size() == 0) ? 0 : q[0].s);
        end
        foreach (q[i]) begin
            n_checks++;
            if (q[i].s !== 10'(8 * ((i % BW) + (i / BW)) + 4) ||
                q[i].x !== 9'(i % BW) || q[i].y !== 8'(i / BW) || q[i].fd !== (i == NB - 1)) begin
                n_fail++;
                $display("FAIL %s_block%0d: got sum=%0d (%0d,%0d) fd=%b, want sum=%0d (%0d,%0d)",
                         name, i, q[i].s, q[i].x, q[i].y, q[i].fd,
                         8 * ((i % BW) + (i / BW)) + 4, i % BW, i / BW);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y == 3 && x == 5) break;
                if (y <= 3) begin
                    ce       = 1'b1;
                    gray_int = 8'((x + y) & 255);
                    tick();
                    ce = 1'b0;
                end
            end
        end
        ce       = 1'b1;
        gray_int = 8'd99;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        ce  = 1'b0;
        n_checks++;
        if (block_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b, want 0", block_valid);
        end
        q.delete();
        tick();
        drive_frame(0, 8'd50);
        n_checks++;
        if (q.size() != NB) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d valids, want %0d", q.size(), NB);
        end
        n_checks++;
        if (q.size() == 0 || q[0].s !== 10'd200 || q[0].x !== 9'd0 || q[0].y !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_first: got sum=%0d (%0d,%0d), want sum=200 (0,0)",
                     (q.size() == 0) ? 0 : q[0].s, (q.size() == 0) ? 0 : q[0].x, (q.size() == 0) ? 0 : q[0].y);
        end
        foreach (q[i]) begin
            n_checks++;
            if (q[i].s !== 10'd200) begin
                n_fail++;
                $display("FAIL midreset_block%0d: got %0d, want 200", i, q[i].s);
            end
        end
    endtask

`ifdef FRAME_SYNC_EN
    task automatic test_frame_sync();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y == 1 && x == 3) break;
                ce       = 1'b1;
                gray_int = 8'((x + y) & 255);
                tick();
                ce = 1'b0;
            end
        end
        q.delete();
        ce       = 1'b1;
        sof      = 1'b1;
        gray_int = 8'd7;
        tick();
        ce  = 1'b0;
        sof = 1'b0;
        n_checks++;
        if (block_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_valid: got %b, want 0", block_valid);
        end
        for (int p = 1; p < H * V; p++) begin
            ce       = 1'b1;
            gray_int = 8'd7;
            tick();
            ce = 1'b0;
        end
        tick();
        n_checks++;
        if (q.size() != NB) begin
            n_fail++;
            $display("FAIL sof_count: got %0d valids, want %0d", q.size(), NB);
        end
        n_checks++;
        if (q.size() == 0 || q[0].x !== 9'd0 || q[0].y !== 8'd0) begin
            n_fail++;
            $display("FAIL sof_first_pos: got (%0d,%0d), want (0,0)",
                     (q.size() == 0) ? 0 : q[0].x, (q.size() == 0) ? 0 : q[0].y);
        end
        foreach (q[i]) begin
            n_checks++;
            if (q[i].s !== 10'd28) begin
                n_fail++;
                $display("FAIL sof_block%0d: got %0d, want 28", i, q[i].s);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_constant(8'd100, 10'd400, "const100");
        test_ramp(1'b0, "ramp");
        test_constant(8'd255, 10'd1020, "const255");
        test_ramp(1'b1, "ramp_gaps");
        test_reset_midframe();
`ifdef FRAME_SYNC_EN
        test_frame_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
